// File: rtl/chan_sel_mux_pkg.sv
// Shared constants and helpers for the channel selector.
// Optional round-robin arbitration is enabled by CHAN_SEL_MUX_RR_EN.
package chan_sel_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 3;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int next_idx(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/chan_sel_mux_arb.sv
// Channel arbiter: fixed highest-index priority, or round-robin
// from pointer+1 when CHAN_SEL_MUX_RR_EN is defined.
module chan_sel_arb
  import chan_sel_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SELW     = sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] elig_i,
`ifdef CHAN_SEL_MUX_RR_EN
  input  logic [SELW-1:0]     ptr_i,
`endif
  output logic [CHANNELS-1:0] gnt_o,
  output logic [SELW-1:0]     idx_o,
  output logic                any_o
);

`ifdef CHAN_SEL_MUX_RR_EN
  always_comb begin
    logic [SELW-1:0] c;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = ptr_i;
    for (int k = 0; k < CHANNELS; k++) begin
      c = SELW'(next_idx(int'(c), CHANNELS));
      if (!any_o && elig_i[c]) begin
        gnt_o[c] = 1'b1;
        idx_o    = c;
        any_o    = 1'b1;
      end
    end
  end
`else
  // Later (higher) indices overwrite earlier ones.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (elig_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = SELW'(i);
        any_o    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/chan_sel_mux.sv
// Registered N-channel valid/ready selector with forced-select mode.
// Define CHAN_SEL_MUX_RR_EN for round-robin, else fixed priority.
module chan_sel_mux
  import chan_sel_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SELW     = sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      force_en,
  input  logic [SELW-1:0]           force_sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    data_q, data_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic                valid_q, valid_d;
  logic [CHANNELS-1:0] elig, gnt;
  logic [SELW-1:0]     gnt_idx;
  logic                any, load, xfer;
  logic [WIDTH-1:0]    word;

  // Out-of-range force_sel matches no index, so nothing is eligible.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      elig[i] = in_valid[i] &
        (!force_en || force_sel == SELW'(i));
    end
  end

`ifdef CHAN_SEL_MUX_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;

  chan_sel_arb #(
    .CHANNELS(CHANNELS),
    .SELW    (SELW)
  ) u_arb (
    .elig_i(elig),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= SELW'(CHANNELS - 1);
    else     ptr_q <= ptr_d;
  end
`else
  chan_sel_arb #(
    .CHANNELS(CHANNELS),
    .SELW    (SELW)
  ) u_arb (
    .elig_i(elig),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any)
  );
`endif

  assign load     = !valid_q || out_ready;
  assign in_ready = (load && !rst) ? gnt : '0;
  assign xfer     = any && load && !rst;

  always_comb begin
    word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt[i]) word = word | in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = word;
      sel_d   = gnt_idx;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_chan_sel_mux.sv
// Scoreboard bench for chan_sel_mux, CHANNELS=3, WIDTH=8.
// Expectations track CHAN_SEL_MUX_RR_EN when it is defined.
module tb_chan_sel_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic        force_en;
  logic [1:0]  force_sel;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  chan_sel_mux dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .force_en (force_en),
    .force_sel(force_sel),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input int d);
    exp_t e;
    e.sel  = 2'(s);
    e.data = 8'(d);
    exp_q.push_back(e);
  endtask

  // Monitor: a word is consumed at the edge after valid&ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_word: got sel=%0d data=%0h",
                 out_sel, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("mon_sel", int'(out_sel), int'(e.sel));
        chk("mon_data", int'(out_data), int'(e.data));
      end
    end
  end

`ifdef CHAN_SEL_MUX_RR_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  int rr_sel[4] = '{0, 1, 2, 0};
  int rr_dat[4] = '{'h11, 'h22, 'h33, 'h11};

  initial begin
    rst       = 1'b1;
    in_data   = {8'h33, 8'h22, 8'h11};
    in_valid  = 3'b111;
    force_en  = 1'b0;
    force_sel = 2'd0;
    out_ready = 1'b1;

    cyc();
    cyc();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sel", int'(out_sel), 0);
    chk("rst_ready", int'(in_ready), 0);

    // Streaming, one word per cycle
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (RR != 0) begin
        chk("stream_ready", int'(in_ready),
            1 << rr_sel[k]);
        push(rr_sel[k], rr_dat[k]);
      end else begin
        chk("stream_ready", int'(in_ready), 3'b100);
        push(2, 'h33);
      end
      cyc();
      chk("stream_valid", int'(out_valid), 1);
    end

    // Load 0x22 then back-pressure
    in_valid = 3'b010;
    push(1, 'h22);
    cyc();
    in_valid  = 3'b111;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_data", int'(out_data), 'h22);
      chk("bp_valid", int'(out_valid), 1);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_ready), 3'b100);
    push(2, 'h33);
    cyc();
    chk("bp_nobubble", int'(out_valid), 1);

    // Forced select
    force_en  = 1'b1;
    force_sel = 2'd1;
    in_valid  = 3'b101;
    #1;
    chk("force1_ready", int'(in_ready), 0);
    cyc();
    chk("force1_valid", int'(out_valid), 0);
    force_sel = 2'd3;
    in_valid  = 3'b111;
    #1;
    chk("force3_ready", int'(in_ready), 0);
    cyc();
    chk("force3_valid", int'(out_valid), 0);
    force_sel = 2'd0;
    #1;
    chk("force0_ready", int'(in_ready), 3'b001);
    push(0, 'h11);
    cyc();
    force_en = 1'b0;
    in_valid = 3'b000;
    cyc();
    chk("drain_valid", int'(out_valid), 0);

    // Reset mid-stream discards the held word
    in_valid  = 3'b010;
    out_ready = 1'b0;
    cyc();
    chk("held_data", int'(out_data), 'h22);
    in_valid = 3'b111;
    rst      = 1'b1;
    #1;
    chk("midrst_ready", int'(in_ready), 0);
    cyc();
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    if (RR != 0) begin
      chk("post_rst_ready", int'(in_ready), 3'b001);
      push(0, 'h11);
    end else begin
      chk("post_rst_ready", int'(in_ready), 3'b100);
      push(2, 'h33);
    end
    cyc();
    in_valid = 3'b000;
    cyc();
    cyc();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
